race_state_ctrl: RTL
====================

# race_state_ctrl

Game-flow controller for the racing game, and the parametrised successor to the single-car `game_state` block. It supports NUM_CARS cars, a multi-lap race and a start countdown. Per-pixel collision and finish-line overlap are evaluated once per frame, and lap counts are kept per car. It drives the state enables that `graphics` and `song1` consume. It sits between `vga_sync`/`graphics` (pixel flags) and `keyboard` (enter events).

## Interface
Parameters:
- NUM_CARS, 2: number of cars, 1..4.
- LAPS, 3: laps needed to win, 1..15.
- COUNT_SEC, 3: countdown length in seconds, 1..7.
- FRAMES_PER_SEC, 60: frame_tick pulses per countdown second, 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, at the start of vertical blank.
- video_on  in  1  pixel is in the visible area.
- road_on  in  1  current pixel is road.
- finish_line  in  1  current pixel is finish line.
- car_on  in  NUM_CARS  current pixel belongs to car i.
- enter_key  in  1  enter key make/break indication from `keyboard`.
- key_relese  in  1  break-code flag from `keyboard`.
- start_en  out  1  IDLE start screen.
- count_en  out  1  COUNTDOWN active.
- crash_en  out  1  CRASH screen.
- finish_en  out  1  FINISH screen.
- pause  out  1  motion and audio halted.
- game_reset  out  1  one-cycle positional reset to `graphics`.
- count_val  out  3  seconds remaining in the countdown.
- laps  out  4*NUM_CARS  lap count per car; car i uses bits [4i+3:4i].
- winner  out  2  index of the winning car.
- crashed  out  NUM_CARS  cars that caused the crash.

## Operation
- Enter event: a one-cycle pulse when (enter_key & ~key_relese) rises. It is registered and edge-detected internally. Holding the key gives only one event.
- Per-frame accumulators, OR-ed over all pixels of a frame, for each car i:
  - hit[i] = car_on[i] & video_on & ~road_on & ~finish_line.
  - ovl[i] = car_on[i] & video_on & finish_line.
  - Accumulators clear on the cycle after frame_tick.
- The previous-frame copy ovl_d[i] is captured at frame_tick.
- States:
  - IDLE. Enter event -> COUNTDOWN. count_val loads COUNT_SEC, laps, crashed and winner clear, and the frame divider clears.
  - COUNTDOWN. Each FRAMES_PER_SEC frame_ticks decrement count_val. The frame_tick that takes count_val from 1 to 0 -> RUN. Enter events are ignored.
  - RUN. Frame evaluation happens at frame_tick:
    - Any hit: crashed is loaded with hit, -> CRASH.
    - Otherwise, for each car with ovl[i] & ~ovl_d[i]: laps[i]++, saturating at LAPS.
    - If any lap count reaches LAPS: winner = lowest such index, -> FINISH.
    - Crash takes priority over finish in the same frame. In that case laps do not increment.
  - Enter event in RUN -> PAUSE.
  - PAUSE. Enter event -> RUN. Accumulators are ignored while paused, and ovl_d is frozen.
  - CRASH and FINISH. Enter event -> IDLE, with game_reset pulsed for exactly one cycle.
- Output decode is registered and one-hot:
  - start_en=IDLE, count_en=COUNTDOWN, crash_en=CRASH, finish_en=FINISH.
  - pause=1 in IDLE, COUNTDOWN, PAUSE, CRASH and FINISH; pause=0 only in RUN.
- Width rules:
  - The frame divider is 8 bits and wraps to 0 at FRAMES_PER_SEC-1.
  - laps fields are 4 bits and saturate at LAPS.
  - winner is zero-extended when NUM_CARS<4.

## Timing
- Reset values (reset=0, asynchronous):
  - State IDLE, start_en=1, pause=1, game_reset=1.
  - All other outputs 0, accumulators 0.
- game_reset deasserts on the first clk edge after reset is released.
- Enter event to state change: 2 cycles (synchroniser/edge stage, then the state register). Outputs are valid on the same edge as the state change.
- frame_tick to RUN evaluation result: 1 cycle. The accumulators include pixels up to and including the frame_tick cycle.
- If an enter event and frame_tick arrive in the same cycle in RUN, the enter event (-> PAUSE) wins and that frame is discarded.
- Reset asserted mid-race returns to IDLE immediately, with all counters cleared.

## Test plan
Bench parameters: NUM_CARS=2, LAPS=2, COUNT_SEC=3, FRAMES_PER_SEC=2.
- Reset released, then one enter press -> 2 cycles later count_en=1, count_val=3. After 2/4/6 frame_ticks, count_val=2/1/0, and RUN is entered (pause=0) at tick 6.
- Car 1 overlaps finish_line in frames 2 and 3, then again in frame 5 -> laps[7:4]=1 after frame 2, unchanged after frame 3. After frame 5, laps[7:4]=2, finish_en=1, winner=1.
- Both cars complete their second lap in the same frame -> winner=0, laps=8'h22.
- In one frame, car 0 is off-road and car 1 is crossing for its final lap -> crash_en=1, crashed=2'b01, finish_en=0, laps[7:4] unchanged.
- Enter in RUN -> pause=1. A frame with an off-road pixel while paused -> no crash. Second enter -> RUN resumes with crashed=0.
- In CRASH, an enter press -> game_reset is high for exactly 1 cycle, start_en=1, and laps=0. Reset pulled low during COUNTDOWN -> IDLE at once with count_val=0.

Source files
------------

// File: rtl/race_state_ctrl.sv
// race_state_ctrl: game-flow controller for an N-car, multi-lap race with a
// start countdown. Pixel flags are OR-accumulated across a frame and judged
// once per frame_tick. The state enables drive graphics and audio.
//
// Handshake note: there is no valid/ready pair here. Every event input is a
// single-cycle strobe (frame_tick), or is turned into one by the internal
// enter edge detector. Every output is a registered level.
module race_state_ctrl #(
  parameter int NUM_CARS       = 2,
  parameter int LAPS           = 3,
  parameter int COUNT_SEC      = 3,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    video_on,
  input  logic                    road_on,
  input  logic                    finish_line,
  input  logic [NUM_CARS-1:0]     car_on,
  input  logic                    enter_key,
  input  logic                    key_relese,
  output logic                    start_en,
  output logic                    count_en,
  output logic                    crash_en,
  output logic                    finish_en,
  output logic                    pause,
  output logic                    game_reset,
  output logic [2:0]              count_val,
  output logic [4*NUM_CARS-1:0]   laps,
  output logic [1:0]              winner,
  output logic [NUM_CARS-1:0]     crashed
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_RUN, S_PAUSE, S_CRASH, S_FINISH
  } state_t;

  localparam logic [3:0] LAPS_V    = 4'(LAPS);
  localparam logic [2:0] COUNT_V   = 3'(COUNT_SEC);
  localparam logic [7:0] DIV_LAST  = 8'(FRAMES_PER_SEC - 1);

  state_t                  state_q, state_d;
  logic                    raw_q, evt_q;
  logic [NUM_CARS-1:0]     hit_acc_q, ovl_acc_q, ovl_prev_q, ovl_prev_d;
  logic [NUM_CARS-1:0]     hit_now, ovl_now, hit_frame, ovl_frame, rise;
  logic [2:0]              count_q, count_d;
  logic [7:0]              div_q, div_d;
  logic [4*NUM_CARS-1:0]   laps_q, laps_d;
  logic [1:0]              winner_q, winner_d;
  logic [NUM_CARS-1:0]     crashed_q, crashed_d;
  logic                    greset_d;
  logic [3:0]              lap_cur, lap_new;
  logic                    won;
  logic                    start_q, count_en_q, crash_q, finish_q, pause_q, greset_q;

  // Collision and overlap flags for the current pixel. The frame value also
  // includes the frame_tick cycle itself.
  assign hit_now   = car_on & {NUM_CARS{video_on & ~road_on & ~finish_line}};
  assign ovl_now   = car_on & {NUM_CARS{video_on & finish_line}};
  assign hit_frame = hit_acc_q | hit_now;
  assign ovl_frame = ovl_acc_q | ovl_now;
  assign rise      = ovl_frame & ~ovl_prev_q;

  // Register the make code and emit one event per press, so holding the key counts once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      raw_q <= enter_key & ~key_relese;
      evt_q <= (enter_key & ~key_relese) & ~raw_q;
    end
  end

  // Per-frame pixel accumulators; they only gather while racing and restart after each tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_acc_q <= '0;
      ovl_acc_q <= '0;
    end else if (state_q != S_RUN || frame_tick) begin
      hit_acc_q <= '0;
      ovl_acc_q <= '0;
    end else begin
      hit_acc_q <= hit_frame;
      ovl_acc_q <= ovl_frame;
    end
  end

  // Next-state, countdown, lap, and result logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    div_d      = div_q;
    laps_d     = laps_q;
    winner_d   = winner_q;
    crashed_d  = crashed_q;
    ovl_prev_d = ovl_prev_q;
    greset_d   = 1'b0;
    lap_cur    = '0;
    lap_new    = '0;
    won        = 1'b0;
    case (state_q)
      S_IDLE: if (evt_q) begin
        state_d    = S_COUNT;
        count_d    = COUNT_V;
        div_d      = '0;
        laps_d     = '0;
        winner_d   = '0;
        crashed_d  = '0;
        ovl_prev_d = '0;
      end
      S_COUNT: if (frame_tick) begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          count_d = count_q - 3'd1;
          if (count_q == 3'd1) state_d = S_RUN;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_RUN: begin
        // A pause request beats a simultaneous frame, and that frame is dropped
        if (evt_q) begin
          state_d = S_PAUSE;
        end else if (frame_tick) begin
          ovl_prev_d = ovl_frame;
          if (|hit_frame) begin
            crashed_d = hit_frame;
            state_d   = S_CRASH;
          end else begin
            // Walk downward so the lowest finishing index is written last
            for (int i = NUM_CARS - 1; i >= 0; i--) begin
              lap_cur = laps_q[4*i +: 4];
              lap_new = (rise[i] && lap_cur < LAPS_V) ? lap_cur + 4'd1 : lap_cur;
              laps_d[4*i +: 4] = lap_new;
              if (lap_new == LAPS_V) begin
                won      = 1'b1;
                winner_d = 2'(i);
              end
            end
            if (won) state_d = S_FINISH;
          end
        end
      end
      S_PAUSE: if (evt_q) state_d = S_RUN;
      S_CRASH, S_FINISH: if (evt_q) begin
        state_d   = S_IDLE;
        greset_d  = 1'b1;
        laps_d    = '0;
        winner_d  = '0;
        crashed_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, with outputs decoded from the next state so they change on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      div_q      <= '0;
      laps_q     <= '0;
      winner_q   <= '0;
      crashed_q  <= '0;
      ovl_prev_q <= '0;
      start_q    <= 1'b1;
      count_en_q <= 1'b0;
      crash_q    <= 1'b0;
      finish_q   <= 1'b0;
      pause_q    <= 1'b1;
      greset_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      laps_q     <= laps_d;
      winner_q   <= winner_d;
      crashed_q  <= crashed_d;
      ovl_prev_q <= ovl_prev_d;
      start_q    <= (state_d == S_IDLE);
      count_en_q <= (state_d == S_COUNT);
      crash_q    <= (state_d == S_CRASH);
      finish_q   <= (state_d == S_FINISH);
      pause_q    <= (state_d != S_RUN);
      greset_q   <= greset_d;
    end
  end

  assign start_en   = start_q;
  assign count_en   = count_en_q;
  assign crash_en   = crash_q;
  assign finish_en  = finish_q;
  assign pause      = pause_q;
  assign game_reset = greset_q;
  assign count_val  = count_q;
  assign laps       = laps_q;
  assign winner     = winner_q;
  assign crashed    = crashed_q;

endmodule
